// File: rtl/game_clock_core_if.sv
// Control pulses in, packed per-player mm:ss clocks and status out.
// The master side drives the button pulses; the slave side is the clock core.
interface game_clock_core_if #(
  parameter int N_PLAYERS = 2,
  parameter int AW        = 3
);
  logic                   start;
  logic                   pause;
  logic                   set_min;
  logic                   set_sec;
  logic [5:0]             inc_sec;
  logic                   turn_done;
  logic [N_PLAYERS*7-1:0] min_out;
  logic [N_PLAYERS*6-1:0] sec_out;
  logic [AW-1:0]          active;
  logic [1:0]             state;
  logic [N_PLAYERS-1:0]   flag;

  modport master (
    output start, pause, set_min, set_sec, inc_sec, turn_done,
    input  min_out, sec_out, active, state, flag
  );

  modport slave (
    input  start, pause, set_min, set_sec, inc_sec, turn_done,
    output min_out, sec_out, active, state, flag
  );
endinterface

// File: rtl/game_clock_core.sv
// N-player game clock: per-player mm:ss down-counters, turn rotation with Fischer
// increment, pause and timeout flagging. Outputs are registered; pulses act the cycle they are high.
module game_clock_core #(
  parameter int N_PLAYERS = 2,
  parameter int TICK_DIV  = 100000000,
  parameter int INIT_MIN  = 5,
  parameter int MAX_MIN   = 99,
  parameter int AW        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  game_clock_core_if.slave bus
);

  localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP    = PW'(TICK_DIV - 1);
  localparam logic [6:0]    MAX_M  = 7'(MAX_MIN);
  localparam logic [6:0]    INIT_M = 7'(INIT_MIN);
  localparam logic [AW-1:0] LAST   = AW'(N_PLAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_FLAG  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        active_q, active_d;
  logic [N_PLAYERS-1:0] flag_q, flag_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [6:0]           min_q [N_PLAYERS];
  logic [6:0]           min_d [N_PLAYERS];
  logic [5:0]           sec_q [N_PLAYERS];
  logic [5:0]           sec_d [N_PLAYERS];

  // Fischer increment with carry into minutes, saturating at MAX_MIN:59.
  function automatic logic [12:0] add_inc(input logic [6:0] m, input logic [5:0] s,
                                          input logic [5:0] inc);
    logic [6:0] ssum;
    logic [7:0] msum;
    ssum = {1'b0, s} + {1'b0, inc};
    msum = {1'b0, m};
    if (ssum >= 7'd60) begin
      ssum = ssum - 7'd60;
      msum = msum + 8'd1;
    end
    if (ssum > 7'd59) ssum = 7'd59;
    if (msum > {1'b0, MAX_M}) return {MAX_M, 6'd59};
    return {msum[6:0], ssum[5:0]};
  endfunction

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    flag_d   = flag_q;
    presc_d  = presc_q;
    for (int i = 0; i < N_PLAYERS; i++) begin
      min_d[i] = min_q[i];
      sec_d[i] = sec_q[i];
    end

    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (bus.set_min) min_d[i] = (min_q[i] == MAX_M) ? 7'd0 : min_q[i] + 7'd1;
          if (bus.set_sec) sec_d[i] = (sec_q[i] == 6'd50) ? 6'd0 : sec_q[i] + 6'd10;
        end
        if (bus.start && (min_q[0] != 7'd0 || sec_q[0] != 6'd0)) begin
          state_d  = S_RUN;
          active_d = '0;
          presc_d  = '0;
        end
      end

      S_RUN: begin
        // Handover beats both pause and a coincident tick.
        if (bus.turn_done) begin
          presc_d  = '0;
          active_d = (active_q == LAST) ? '0 : active_q + 1'b1;
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (AW'(i) == active_q) {min_d[i], sec_d[i]} = add_inc(min_q[i], sec_q[i], bus.inc_sec);
          end
        end else if (bus.pause) begin
          state_d = S_PAUSE;
        end else if (presc_q == TOP) begin
          presc_d = '0;
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (AW'(i) == active_q) begin
              if (sec_q[i] != 6'd0) begin
                sec_d[i] = sec_q[i] - 6'd1;
              end else if (min_q[i] != 7'd0) begin
                min_d[i] = min_q[i] - 7'd1;
                sec_d[i] = 6'd59;
              end else begin
                flag_d[i] = 1'b1;
                state_d   = S_FLAG;
              end
            end
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      S_PAUSE: begin
        if (bus.pause) state_d = S_RUN;
      end

      default: begin
        if (bus.start) begin
          state_d  = S_IDLE;
          active_d = '0;
          flag_d   = '0;
          for (int i = 0; i < N_PLAYERS; i++) begin
            min_d[i] = INIT_M;
            sec_d[i] = 6'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      flag_q   <= '0;
      presc_q  <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        min_q[i] <= INIT_M;
        sec_q[i] <= 6'd0;
      end
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      flag_q   <= flag_d;
      presc_q  <= presc_d;
      for (int i = 0; i < N_PLAYERS; i++) begin
        min_q[i] <= min_d[i];
        sec_q[i] <= sec_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      bus.min_out[7*i +: 7] = min_q[i];
      bus.sec_out[6*i +: 6] = sec_q[i];
    end
  end

  assign bus.active = active_q;
  assign bus.state  = state_q;
  assign bus.flag   = flag_q;

endmodule
